// File: rtl/fpu_pkg.sv
// Shared F-extension definitions: rounding modes, fflags layout,
// binary32 field geometry and the pipeline bundles of fcvt_wu_s.
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SIG_W = MAN_W + 1;
  localparam int BIAS  = 127;

  localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;
  localparam logic [31:0] UINT_MIN = 32'h0000_0000;

  typedef enum logic [1:0] {
    CLS_FIN,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } cls_e;

  typedef struct packed {
    logic             v;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    cls_e             cls;
    logic [2:0]       rm;
  } s1_t;

  typedef struct packed {
    logic        v;
    logic        sign;
    cls_e        cls;
    logic [2:0]  rm;
    logic        ovf;
    logic [31:0] ip;
    logic        g;
    logic        s;
  } s2_t;

endpackage

// File: rtl/fp_round_incr.sv
// Rounding-increment decision shared by the F-extension converters
// and the FMA rounder.
module fp_round_incr
  import fpu_pkg::*;
(
  input  logic [2:0] i_rm,
  input  logic       i_sign,
  input  logic       i_lsb,
  input  logic       i_guard,
  input  logic       i_sticky,
  output logic       o_incr
);

  logic w_inx;
  assign w_inx = i_guard | i_sticky;

  // Reserved encodings fall through to the RNE default.
  always_comb begin
    o_incr = i_guard & (i_sticky | i_lsb);
    unique case (1'b1)
      (i_rm == RM_RTZ): o_incr = 1'b0;
      (i_rm == RM_RDN): o_incr = i_sign & w_inx;
      (i_rm == RM_RUP): o_incr = ~i_sign & w_inx;
      (i_rm == RM_RMM): o_incr = i_guard;
      default: ;
    endcase
  end

endmodule

// File: rtl/fcvt_wu_s.sv
// FCVT.WU.S: binary32 -> uint32, 3-stage pipeline
// (unpack, align, round/saturate) with RISC-V saturation and fflags.
module fcvt_wu_s
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_input,
  input  logic [31:0] a,
  input  logic [2:0]  rm,
  output logic        valid_output,
  output logic [31:0] y,
  output logic [4:0]  fflags
);

  s1_t r_s1, w_s1;
  s2_t r_s2, w_s2;

  logic        r_vo;
  logic [31:0] r_y;
  logic [4:0]  r_ff;

  logic w_exp_max, w_exp_zero, w_frac_nz;

  assign w_exp_max  = &a[30:23];
  assign w_exp_zero = ~|a[30:23];
  assign w_frac_nz  = |a[22:0];

  always_comb begin
    w_s1      = '0;
    w_s1.v    = valid_input;
    w_s1.sign = a[31];
    w_s1.exp  = a[30:23];
    w_s1.sig  = {~w_exp_zero, a[22:0]};
    w_s1.rm   = rm;
    w_s1.cls  = CLS_FIN;
    unique case (1'b1)
      (w_exp_max & w_frac_nz):   w_s1.cls = CLS_NAN;
      (w_exp_max & ~w_frac_nz):  w_s1.cls = CLS_INF;
      (w_exp_zero & ~w_frac_nz): w_s1.cls = CLS_ZERO;
      default: ;
    endcase
  end

  logic signed [9:0] w_e;
  logic [54:0]       w_sh;

  assign w_e  = $signed({2'b00, r_s1.exp})
              - $signed(10'(BIAS));
  assign w_sh = {31'b0, r_s1.sig} << w_e[4:0];

  // Bit 23 of the shifted value is the binary point.
  always_comb begin
    w_s2      = '0;
    w_s2.v    = r_s1.v;
    w_s2.sign = r_s1.sign;
    w_s2.cls  = r_s1.cls;
    w_s2.rm   = r_s1.rm;
    w_s2.ovf  = (w_e > 10'sd31);
    if (!w_e[9]) begin
      w_s2.ip = w_sh[54:23];
      w_s2.g  = w_sh[22];
      w_s2.s  = |w_sh[21:0];
    end else begin
      w_s2.g  = (w_e == -10'sd1);
      w_s2.s  = w_s2.g ? |r_s1.sig[MAN_W-1:0]
                       : |r_s1.sig;
    end
  end

  logic        w_incr;
  logic [32:0] w_sum;
  logic        w_inx, w_ovf;
  logic [31:0] w_y;
  logic [4:0]  w_ff;

  fp_round_incr u_rnd (
    .i_rm     (r_s2.rm),
    .i_sign   (r_s2.sign),
    .i_lsb    (r_s2.ip[0]),
    .i_guard  (r_s2.g),
    .i_sticky (r_s2.s),
    .o_incr   (w_incr)
  );

  assign w_sum = {1'b0, r_s2.ip} + 33'(w_incr);
  assign w_inx = r_s2.g | r_s2.s;
  assign w_ovf = r_s2.ovf | w_sum[32];

  always_comb begin
    w_y  = UINT_MIN;
    w_ff = '0;
    unique case (1'b1)
      (r_s2.cls == CLS_NAN): begin
        w_y          = UINT_MAX;
        w_ff[FLAG_NV] = 1'b1;
      end
      (r_s2.cls == CLS_INF): begin
        w_y          = r_s2.sign ? UINT_MIN : UINT_MAX;
        w_ff[FLAG_NV] = 1'b1;
      end
      (r_s2.cls == CLS_ZERO): ;
      (r_s2.cls == CLS_FIN && r_s2.sign): begin
        if (w_ovf || |w_sum[31:0])
          w_ff[FLAG_NV] = 1'b1;
        else
          w_ff[FLAG_NX] = w_inx;
      end
      default: begin
        if (w_ovf) begin
          w_y           = UINT_MAX;
          w_ff[FLAG_NV] = 1'b1;
        end else begin
          w_y           = w_sum[31:0];
          w_ff[FLAG_NX] = w_inx;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_vo <= 1'b0;
      r_y  <= '0;
      r_ff <= '0;
    end else begin
      r_s1 <= w_s1;
      r_s2 <= w_s2;
      r_vo <= r_s2.v;
      if (r_s2.v) begin
        r_y  <= w_y;
        r_ff <= w_ff;
      end
    end
  end

  assign valid_output = r_vo;
  assign y            = r_y;
  assign fflags       = r_ff;

endmodule

// File: doc/fcvt_wu_s.md
Name: fcvt_wu_s

Overview:
Converts an IEEE-754 binary32 operand to an unsigned 32-bit integer, implementing RISC-V FCVT.WU.S. It is the reverse path of the unsigned-int-to-float converter in the F-extension execute stage. The block is a fixed 3-stage pipeline accepting one operation per cycle, with valid_input/valid_output qualification. It produces the RISC-V saturated result plus fflags contributions.

Parameters:
none; format fixed to binary32 in, uint32 out, latency fixed at 3.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid_input  input  1  operand valid this cycle
a  input  32  binary32 operand
rm  input  3  resolved rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101..111 treated as RNE
valid_output  output  1  y/fflags valid this cycle
y  output  32  unsigned integer result
fflags  output  5  {NV,DZ,OF,UF,NX}; DZ/OF/UF always 0

Behaviour:
- One clock; reset is asynchronous and active-low; ports clk and rst_n.
- Reset clears valid_output, y and fflags to 0, and flushes all stage valids. In-flight operations are discarded; no output pulse follows reset release.
- Fully pipelined, no stall or back-pressure. An operand with valid_input=1 at edge N produces valid_output=1 at edge N+3 with its result.
- Back-to-back inputs give back-to-back outputs in order.
- When valid_input=0, bubbles propagate. While valid_output=0, y and fflags hold their last values (no toggling on bubbles).
- S1 (unpack/classify):
  - Latch sign, biased exponent and mantissa with hidden bit (0 for subnormals).
  - Classify as NaN, inf, zero, or finite.
  - Latch rm.
- S2 (align):
  - Unbiased exponent e = exp-127.
  - e > 31 is overflow.
  - 0 <= e <= 31: shift significand to 32-bit integer part plus guard bit and sticky bit.
  - e < 0: integer part 0; guard = (e == -1); sticky = remaining bits OR (e < -1 and significand != 0).
- S3 (round/saturate):
  - Rounding increment:
    - RNE: G&(S|lsb)
    - RTZ: 0
    - RDN: sign&(G|S)
    - RUP: ~sign&(G|S)
    - RMM: G
  - Positive rounded magnitude is computed in 33 bits. A carry into bit 32 is overflow.
- Result rules, in priority order:
  - NaN (any payload, either sign) -> 0xFFFFFFFF, NV=1.
  - +inf or positive overflow -> 0xFFFFFFFF, NV=1.
  - -inf -> 0, NV=1.
  - ±0 -> 0, flags 0.
  - Negative finite, rounded magnitude nonzero -> 0, NV=1.
  - Negative finite, rounded magnitude zero (e.g. -0.3 under RTZ) -> 0, NX=1 if G|S, NV=0.
  - Otherwise: rounded magnitude; NX = G|S.
- NV and NX are never both 1.
- Subnormals are converted, never flushed; they always round to 0 or 1 (+) with NX=1.

Decomposition:
- fpu_pkg (shared), containing:
  - rm encodings and the fflags bit indices
  - binary32 field widths and BIAS=127
  - the canonical saturation constants UINT_MAX=0xFFFFFFFF and UINT_MIN=0
- Sub-module fp_round_incr (combinational): (rm, sign, lsb, guard, sticky) -> increment. It is reused later by fcvt_w_s and the FMA rounder.

Test Plan:
- Basic values, RNE, inputs on consecutive cycles:
  - 0x3F800000 (1.0) -> 0x00000001, fflags 0
  - 0x4F7FFFFF -> 0xFFFFFF00, fflags 0
  - 0x00000000 -> 0, fflags 0
  - 0x80000000 -> 0, fflags 0
  - Each output appears exactly 3 cycles after its input, back-to-back.
- 0x40200000 (2.5) under each rm:
  - RNE -> 2
  - RTZ -> 2
  - RDN -> 2
  - RUP -> 3
  - RMM -> 3
  - NX=1 in all cases.
  - 0x3FC00000 (1.5) under RNE -> 2, NX.
- Saturation:
  - 0x4F800000 (2^32) -> 0xFFFFFFFF, NV
  - 0x7F800000 -> 0xFFFFFFFF, NV
  - 0x7FC00000 -> 0xFFFFFFFF, NV
  - 0xFF800000 -> 0, NV
  - 0xBF800000 (-1.0) -> 0, NV
- Negative small, 0xBE99999A (-0.3):
  - RTZ -> 0, NX only
  - RDN -> 0, NV only
  - RNE -> 0, NX only
- Subnormal 0x00000001:
  - RUP -> 1, NX
  - RNE -> 0, NX
- Pipeline control:
  - Inputs valid on cycles 0, 2 and 3 give valid_output on cycles 3, 5 and 6 only, with y unchanged during bubbles.
  - rst_n pulsed low while 2 operations are in flight -> valid_output stays 0 after release and y = 0.
